// File: rtl/sha256_mining_pkg.sv
// Shared types and widths for the SHA256 mining job path.
// Holds the dispatcher state enum and the default hash slot length.
package sha256_mining_pkg;

    localparam int HASH_CYCLES_DEF = 70;
    localparam int NONCE_W         = 32;
    localparam int DIGEST_W        = 256;
    localparam int BLOCK_W         = 640;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/digest_target_compare.sv
// Combinational 256-bit unsigned digest <= target, word a in the MSBs.
// Ports: digest_i, target_i (256b) in; le_o = (digest_i <= target_i) out.
module digest_target_compare
    import sha256_mining_pkg::*;
(
    input  logic [DIGEST_W-1:0] digest_i,
    input  logic [DIGEST_W-1:0] target_i,
    output logic                le_o
);

    localparam int WORDS = DIGEST_W / 32;

    logic [WORDS-1:0] lt;
    logic [WORDS-1:0] eq;

    // Independent 32-bit word compares keep the carry chains short.
    for (genvar g = 0; g < WORDS; g++) begin : g_word
        assign lt[g] = digest_i[g*32 +: 32] <  target_i[g*32 +: 32];
        assign eq[g] = digest_i[g*32 +: 32] == target_i[g*32 +: 32];
    end

    // Fold from the least significant word up; a higher word decides
    // unless it is equal, in which case the lower result stands.
    always_comb begin
        le_o = 1'b1;
        for (int w = 0; w < WORDS; w++) begin
            le_o = lt[w] | (eq[w] & le_o);
        end
    end

endmodule

// File: rtl/sha256_nonce_dispatcher.sv
// Feeds one nonce per hash slot into a pipelined double-SHA256 core,
// checks each final digest against the job target and reports hits.
// Ports: job_* (job offer/handshake), abort, sha_* (core side),
// found_* (hit report), busy/done/protocol_err (status).
module sha256_nonce_dispatcher
    import sha256_mining_pkg::*;
#(
    parameter int HASH_CYCLES  = HASH_CYCLES_DEF,
    parameter int NONCE_LSB    = 0,
    parameter bit STOP_ON_FIND = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [DIGEST_W-1:0] job_midstate,
    input  logic [BLOCK_W-1:0]  job_block,
    input  logic [NONCE_W-1:0]  job_nonce_start,
    input  logic [NONCE_W-1:0]  job_nonce_end,
    input  logic [DIGEST_W-1:0] job_target,
    input  logic                abort,
    output logic                sha_write_en,
    output logic [BLOCK_W-1:0]  sha_block_in,
    output logic [DIGEST_W-1:0] sha_digest_in,
    input  logic [DIGEST_W-1:0] sha_digest_out_2,
    input  logic                sha_valid_out,
    output logic                found_valid,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [DIGEST_W-1:0] found_digest,
    output logic                busy,
    output logic                done,
    output logic                protocol_err
);

    localparam int CYC_W = (HASH_CYCLES > 1) ? $clog2(HASH_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(HASH_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [NONCE_W-1:0]  nonce_cur_q, nonce_cur_d;
    logic [NONCE_W-1:0]  nonce_end_q, nonce_end_d;
    logic [NONCE_W-1:0]  result_nonce_q, result_nonce_d;
    logic                first_q, first_d;
    logic                perr_q, perr_d;
    logic [BLOCK_W-1:0]  block_q, block_d;
    logic [DIGEST_W-1:0] mid_q, mid_d;
    logic [DIGEST_W-1:0] target_q, target_d;
    logic                fv_q, fv_d;
    logic [NONCE_W-1:0]  fnonce_q, fnonce_d;
    logic [DIGEST_W-1:0] fdigest_q, fdigest_d;

    logic le;
    logic eval;
    logic hit;

    digest_target_compare u_cmp (
        .digest_i (sha_digest_out_2),
        .target_i (target_q),
        .le_o     (le)
    );

    // The result of the previous slot lands in cycle 0 of the next slot,
    // or in DRAIN for the last nonce of the range.
    assign eval = ((state_q == ST_RUN) && (cyc_q == '0) && first_q)
                || (state_q == ST_DRAIN);
    assign hit  = eval && sha_valid_out && le;

    always_comb begin
        state_d        = state_q;
        cyc_d          = cyc_q;
        nonce_cur_d    = nonce_cur_q;
        nonce_end_d    = nonce_end_q;
        result_nonce_d = result_nonce_q;
        first_d        = first_q;
        perr_d         = perr_q;
        block_d        = block_q;
        mid_d          = mid_q;
        target_d       = target_q;
        fv_d           = 1'b0;
        fnonce_d       = fnonce_q;
        fdigest_d      = fdigest_q;

        if (eval && !sha_valid_out) begin
            perr_d = 1'b1;
        end
        // Reported even when abort arrives in the same cycle.
        if (hit) begin
            fv_d      = 1'b1;
            fnonce_d  = result_nonce_q;
            fdigest_d = sha_digest_out_2;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    block_d     = job_block;
                    mid_d       = job_midstate;
                    target_d    = job_target;
                    nonce_cur_d = job_nonce_start;
                    nonce_end_d = job_nonce_end;
                    cyc_d       = '0;
                    first_d     = 1'b0;
                    perr_d      = 1'b0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (STOP_ON_FIND && hit)) begin
                    state_d = ST_DONE;
                end else if (cyc_q == CYC_LAST) begin
                    result_nonce_d = nonce_cur_q;
                    first_d        = 1'b1;
                    // Inequality test lets the range wrap through zero.
                    if (nonce_cur_q != nonce_end_q) begin
                        nonce_cur_d = nonce_cur_q + NONCE_W'(1);
                        cyc_d       = '0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            cyc_q          <= '0;
            nonce_cur_q    <= '0;
            nonce_end_q    <= '0;
            result_nonce_q <= '0;
            first_q        <= 1'b0;
            perr_q         <= 1'b0;
            block_q        <= '0;
            mid_q          <= '0;
            target_q       <= '0;
            fv_q           <= 1'b0;
            fnonce_q       <= '0;
            fdigest_q      <= '0;
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            nonce_cur_q    <= nonce_cur_d;
            nonce_end_q    <= nonce_end_d;
            result_nonce_q <= result_nonce_d;
            first_q        <= first_d;
            perr_q         <= perr_d;
            block_q        <= block_d;
            mid_q          <= mid_d;
            target_q       <= target_d;
            fv_q           <= fv_d;
            fnonce_q       <= fnonce_d;
            fdigest_q      <= fdigest_d;
        end
    end

    always_comb begin
        sha_block_in = block_q;
        sha_block_in[NONCE_LSB +: NONCE_W] = nonce_cur_q;
    end

    assign job_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign sha_write_en  = (state_q == ST_RUN);
    assign sha_digest_in = mid_q;
    assign found_valid   = fv_q;
    assign found_nonce   = fnonce_q;
    assign found_digest  = fdigest_q;
    assign protocol_err  = perr_q;

endmodule
